mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between instruction fetch (IF) and the load/store data-memory stage (DM) of the 5-stage RISC-V core.
- Arbitrates requests and sequences each transaction through a request/accept/response handshake.
- Returns read data to the winning requester and drives stall flags into the pipeline flop enables.
- DM has priority, since it serves the older instruction; a starvation limit guarantees fetch progress.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, DM and memory-side handshake signals of the unified memory port.
// The arbiter uses the slave modport; the pipeline/memory environment uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned INSTRUCTION_LENGTH = 32
);
    logic                          if_req;
    logic [XLEN-1:0]               if_addr;
    logic [INSTRUCTION_LENGTH-1:0] if_rdata;
    logic                          if_valid;
    logic                          if_stall;

    logic                          dm_req;
    logic                          dm_we;
    logic [XLEN-1:0]               dm_addr;
    logic [XLEN-1:0]               dm_wdata;
    logic [XLEN-1:0]               dm_rdata;
    logic                          dm_valid;
    logic                          dm_stall;

    logic                          mem_req;
    logic                          mem_we;
    logic [XLEN-1:0]               mem_addr;
    logic [XLEN-1:0]               mem_wdata;
    logic                          mem_ready;
    logic                          mem_rvalid;
    logic [XLEN-1:0]               mem_rdata;

    logic                          timeout_err;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, timeout_err
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store, DM-priority
// with a starvation limit for IF. Optional response watchdog enabled by MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned INSTRUCTION_LENGTH = 32,
    parameter int unsigned STARVE_LIMIT       = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES     = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t                        state, state_d;
    owner_t                        owner, owner_d;
    logic [STREAK_W-1:0]           streak, streak_d;
    logic                          mem_req_q, mem_req_d;
    logic                          mem_we_q, mem_we_d;
    logic [XLEN-1:0]               mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]               mem_wdata_q, mem_wdata_d;
    logic [INSTRUCTION_LENGTH-1:0] if_rdata_q, if_rdata_d;
    logic                          if_valid_q, if_valid_d;
    logic [XLEN-1:0]               dm_rdata_q, dm_rdata_d;
    logic                          dm_valid_q, dm_valid_d;
    logic                          dm_wins;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // Next-state, arbitration and response capture
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        streak_d    = streak;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_valid_d  = 1'b0;
        dm_wins     = bus.dm_req && (!bus.if_req || (streak < STREAK_W'(STARVE_LIMIT)));

        case (state)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
                    if (dm_wins) begin
                        owner_d     = OWN_DM;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                        // A DM win with IF waiting implies streak < limit, so no overflow
                        streak_d    = bus.if_req ? streak + STREAK_W'(1) : '0;
                    end else begin
                        owner_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = IDLE;
                    if (owner == OWN_IF) begin
                        if_rdata_d = bus.mem_rdata[INSTRUCTION_LENGTH-1:0];
                        if_valid_d = 1'b1;
                    end else begin
                        dm_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                        dm_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
        // Watchdog only ages while the FSM stays in the same busy state
        if ((state == REQ || state == WAIT) && state_d == state) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d       = IDLE;
                mem_req_d     = 1'b0;
                timeout_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt + TMO_W'(1);
            end
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            streak      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            streak      <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt       <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.if_stall  = bus.if_req && !if_valid_q;
    assign bus.dm_stall  = bus.dm_req && !dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level model of the port.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned IL    = 32;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned NVEC  = 19;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(XLEN), .INSTRUCTION_LENGTH(IL)) bus ();

    mem_port_arbiter #(
        .XLEN(XLEN),
        .INSTRUCTION_LENGTH(IL),
        .STARVE_LIMIT(LIMIT)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.dm_req     = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_addr    = '0;
        bus.dm_wdata   = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        ifr;  logic [63:0] ia;
        logic        dmr;  logic        we;  logic [63:0] da; logic [63:0] dw;
        logic        rdy;  logic        rv;  logic [63:0] rd;
        logic        e_mreq; logic e_mwe; logic [63:0] e_maddr; logic [63:0] e_mwdata;
        logic        e_ifv; logic [31:0] e_ifd; logic e_dmv; logic [63:0] e_dmd;
        logic        e_ifs; logic e_dms;
    } vec_t;

    function automatic vec_t mk(
        input logic ifr, input logic [63:0] ia, input logic dmr, input logic we,
        input logic [63:0] da, input logic [63:0] dw, input logic rdy, input logic rv,
        input logic [63:0] rd, input logic e_mreq, input logic e_mwe, input logic [63:0] e_maddr,
        input logic [63:0] e_mwdata, input logic e_ifv, input logic [31:0] e_ifd,
        input logic e_dmv, input logic [63:0] e_dmd, input logic e_ifs, input logic e_dms);
        vec_t v;
        v.ifr = ifr; v.ia = ia; v.dmr = dmr; v.we = we; v.da = da; v.dw = dw;
        v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        v.e_ifv = e_ifv; v.e_ifd = e_ifd; v.e_dmv = e_dmv; v.e_dmd = e_dmd;
        v.e_ifs = e_ifs; v.e_dms = e_dms;
        return v;
    endfunction

    vec_t vecs [NVEC];

    // Transaction-level reference model state for the random run
    bit          open, accepted, own_if, own_store;
    int unsigned dm_run, age;
    logic        exp_mreq, exp_mwe, exp_ifv, exp_dmv;
    logic [63:0] exp_maddr, exp_mwdata, exp_dmd;
    logic [31:0] exp_ifd;
    bit          if_pend, dm_pend, dm_st, cur_ifr, cur_dmr, rdy, rv, dm_first;
    logic [63:0] if_a, dm_a, dm_d, rd;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // IF-only fetch, then simultaneous IF/DM, then a store with a slow accept
        vecs[0]  = mk(1, 64'h1000, 0, 0, 0, 0, 0, 1, 64'hAAAA, 1, 0, 64'h1000, 0, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(1, 64'h1000, 0, 0, 0, 0, 1, 1, 64'hBBBB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(1, 64'h1000, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_0000_0013, 0, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h13, 0, 0, 0, 0);
        vecs[4]  = mk(1, 64'h1004, 1, 0, 64'h2000, 0, 0, 0, 0, 1, 0, 64'h2000, 0, 0, 32'h13, 0, 0, 1, 1);
        vecs[5]  = mk(1, 64'h1004, 1, 0, 64'h2000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h13, 0, 0, 1, 1);
        vecs[6]  = mk(1, 64'h1004, 1, 0, 64'h2000, 0, 0, 1, 64'h1122334455667788, 0, 0, 0, 0, 0, 32'h13, 1, 64'h1122334455667788, 1, 0);
        vecs[7]  = mk(1, 64'h1004, 0, 0, 0, 0, 0, 0, 0, 1, 0, 64'h1004, 0, 0, 32'h13, 0, 64'h1122334455667788, 1, 0);
        vecs[8]  = mk(1, 64'h1004, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h13, 0, 64'h1122334455667788, 1, 0);
        vecs[9]  = mk(1, 64'h1004, 0, 0, 0, 0, 0, 1, 64'h0000_0042_0000_0073, 0, 0, 0, 0, 1, 32'h73, 0, 64'h1122334455667788, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h73, 0, 64'h1122334455667788, 0, 0);
        for (int i = 11; i < 16; i++)
            vecs[i] = mk(0, 0, 1, 1, 64'h3008, 64'hDEADBEEF, 0, 0, 0, 1, 1, 64'h3008, 64'hDEADBEEF, 0, 32'h73, 0, 64'h1122334455667788, 0, 1);
        vecs[16] = mk(0, 0, 1, 1, 64'h3008, 64'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0, 0, 32'h73, 0, 64'h1122334455667788, 0, 1);
        vecs[17] = mk(0, 0, 1, 1, 64'h3008, 64'hDEADBEEF, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 32'h73, 1, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h73, 0, 0, 0, 0);

        // Reset values, checked while reset is still asserted
        quiet_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("rst.mem_req", 64'(bus.mem_req), 0);
        check("rst.mem_we", 64'(bus.mem_we), 0);
        check("rst.mem_addr", bus.mem_addr, 0);
        check("rst.mem_wdata", bus.mem_wdata, 0);
        check("rst.if_valid", 64'(bus.if_valid), 0);
        check("rst.if_rdata", 64'(bus.if_rdata), 0);
        check("rst.dm_valid", 64'(bus.dm_valid), 0);
        check("rst.dm_rdata", bus.dm_rdata, 0);
        check("rst.timeout_err", 64'(bus.timeout_err), 0);
        rst = 1'b0;

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            bus.if_req = vecs[i].ifr;   bus.if_addr = vecs[i].ia;
            bus.dm_req = vecs[i].dmr;   bus.dm_we = vecs[i].we;
            bus.dm_addr = vecs[i].da;   bus.dm_wdata = vecs[i].dw;
            bus.mem_ready = vecs[i].rdy; bus.mem_rvalid = vecs[i].rv; bus.mem_rdata = vecs[i].rd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.mem_req", i), 64'(bus.mem_req), 64'(vecs[i].e_mreq));
            if (vecs[i].e_mreq) begin
                check($sformatf("vec%0d.mem_we", i), 64'(bus.mem_we), 64'(vecs[i].e_mwe));
                check($sformatf("vec%0d.mem_addr", i), bus.mem_addr, vecs[i].e_maddr);
                check($sformatf("vec%0d.mem_wdata", i), bus.mem_wdata, vecs[i].e_mwdata);
            end
            check($sformatf("vec%0d.if_valid", i), 64'(bus.if_valid), 64'(vecs[i].e_ifv));
            check($sformatf("vec%0d.if_rdata", i), 64'(bus.if_rdata), 64'(vecs[i].e_ifd));
            check($sformatf("vec%0d.dm_valid", i), 64'(bus.dm_valid), 64'(vecs[i].e_dmv));
            check($sformatf("vec%0d.dm_rdata", i), bus.dm_rdata, vecs[i].e_dmd);
            check($sformatf("vec%0d.if_stall", i), 64'(bus.if_stall), 64'(vecs[i].e_ifs));
            check($sformatf("vec%0d.dm_stall", i), 64'(bus.dm_stall), 64'(vecs[i].e_dms));
        end

        // Async reset while waiting for a response, then a stray rvalid
        @(negedge clk);
        quiet_inputs();
        bus.if_req = 1'b1; bus.if_addr = 64'h6000;
        @(negedge clk);
        check("arst.pre_mem_addr", bus.mem_addr, 64'h6000);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("arst.pre_if_rdata", 64'(bus.if_rdata), 64'h73);
        #1 rst = 1'b1;
        #1;
        check("arst.mem_addr", bus.mem_addr, 0);
        check("arst.if_rdata", 64'(bus.if_rdata), 0);
        check("arst.mem_req", 64'(bus.mem_req), 0);
        bus.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h55;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("arst.stray%0d.if_valid", c), 64'(bus.if_valid), 0);
            check($sformatf("arst.stray%0d.dm_valid", c), 64'(bus.dm_valid), 0);
            check($sformatf("arst.stray%0d.mem_req", c), 64'(bus.mem_req), 0);
        end

        // Starvation: both held, grant order DM x4, IF, DM
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 64'h4000;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h5000;
        for (int k = 0; k < 6; k++) begin
            int waited;
            logic [63:0] exp_a;
            exp_a = (k == 4) ? 64'h4000 : 64'h5000;
            waited = 0;
            while (bus.mem_req !== 1'b1 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            check($sformatf("starve%0d.grant_wait", k), 64'(waited < 10), 1);
            check($sformatf("starve%0d.mem_addr", k), bus.mem_addr, exp_a);
            check($sformatf("starve%0d.if_stall", k), 64'(bus.if_stall), 1);
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'(k);
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            check($sformatf("starve%0d.if_valid", k), 64'(bus.if_valid), 64'(k == 4));
            check($sformatf("starve%0d.dm_valid", k), 64'(bus.dm_valid), 64'(k != 4));
        end
        quiet_inputs();

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never accepts: watchdog fires after 16 cycles in REQ
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 64'h7000;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("tmo%0d.mem_req", c), 64'(bus.mem_req), 1);
            check($sformatf("tmo%0d.timeout_err", c), 64'(bus.timeout_err), 0);
        end
        @(negedge clk);
        check("tmo.mem_req_dropped", 64'(bus.mem_req), 0);
        check("tmo.timeout_err", 64'(bus.timeout_err), 1);
        check("tmo.if_valid", 64'(bus.if_valid), 0);
        bus.if_req = 1'b0;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 64'h7004;
        @(negedge clk);
        check("tmo.retry_addr", bus.mem_addr, 64'h7004);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h99;
        @(negedge clk);
        check("tmo.retry_valid", 64'(bus.if_valid), 1);
        check("tmo.retry_rdata", 64'(bus.if_rdata), 64'h99);
        check("tmo.err_sticky", 64'(bus.timeout_err), 1);
        quiet_inputs();
`endif

        // Randomized run against the transaction-level model
        do_reset();
        open = 0; accepted = 0; own_if = 0; own_store = 0; dm_run = 0; age = 0;
        exp_mreq = 0; exp_mwe = 0; exp_ifv = 0; exp_dmv = 0;
        exp_maddr = 0; exp_mwdata = 0; exp_dmd = 0; exp_ifd = 0;
        if_pend = 0; dm_pend = 0; dm_st = 0; cur_ifr = 0; cur_dmr = 0;
        if_a = 0; dm_a = 0; dm_d = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check($sformatf("rand%0d.mem_req", cyc), 64'(bus.mem_req), 64'(exp_mreq));
            if (exp_mreq) begin
                check($sformatf("rand%0d.mem_we", cyc), 64'(bus.mem_we), 64'(exp_mwe));
                check($sformatf("rand%0d.mem_addr", cyc), bus.mem_addr, exp_maddr);
                check($sformatf("rand%0d.mem_wdata", cyc), bus.mem_wdata, exp_mwdata);
            end
            check($sformatf("rand%0d.if_valid", cyc), 64'(bus.if_valid), 64'(exp_ifv));
            check($sformatf("rand%0d.dm_valid", cyc), 64'(bus.dm_valid), 64'(exp_dmv));
            check($sformatf("rand%0d.if_rdata", cyc), 64'(bus.if_rdata), 64'(exp_ifd));
            check($sformatf("rand%0d.dm_rdata", cyc), bus.dm_rdata, exp_dmd);
            check($sformatf("rand%0d.if_stall", cyc), 64'(bus.if_stall), 64'(cur_ifr && !exp_ifv));
            check($sformatf("rand%0d.dm_stall", cyc), 64'(bus.dm_stall), 64'(cur_dmr && !exp_dmv));

            // Requesters: retire on completion, then maybe issue a new request
            if (exp_ifv) if_pend = 0;
            if (exp_dmv) dm_pend = 0;
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1;
                if_a = {32'($urandom), 32'($urandom)} & ~64'h3;
            end
            if (!dm_pend && $urandom_range(2) == 0) begin
                dm_pend = 1;
                dm_st = 1'($urandom_range(1));
                dm_a = {32'($urandom), 32'($urandom)};
                dm_d = {32'($urandom), 32'($urandom)};
            end
            cur_ifr = if_pend; cur_dmr = dm_pend;
            rdy = ($urandom_range(3) == 0) || (age >= 6);
            rv  = ($urandom_range(3) == 0) || (age >= 6);
            rd  = {32'($urandom), 32'($urandom)};
            bus.if_req = cur_ifr; bus.if_addr = if_a;
            bus.dm_req = cur_dmr; bus.dm_we = dm_st; bus.dm_addr = dm_a; bus.dm_wdata = dm_d;
            bus.mem_ready = rdy; bus.mem_rvalid = rv; bus.mem_rdata = rd;

            // Predict what is visible after the coming edge
            exp_ifv = 0; exp_dmv = 0;
            if (!open) begin
                if (cur_ifr || cur_dmr) begin
                    dm_first = cur_dmr && (!cur_ifr || dm_run < LIMIT);
                    open = 1; accepted = 0; age = 0; exp_mreq = 1;
                    own_if = !dm_first;
                    if (dm_first) begin
                        dm_run = cur_ifr ? ((dm_run < LIMIT) ? dm_run + 1 : dm_run) : 0;
                        own_store = dm_st; exp_mwe = dm_st; exp_maddr = dm_a; exp_mwdata = dm_d;
                    end else begin
                        dm_run = 0;
                        own_store = 0; exp_mwe = 0; exp_maddr = if_a; exp_mwdata = 0;
                    end
                end
            end else if (!accepted) begin
                age++;
                if (rdy) begin
                    accepted = 1; exp_mreq = 0; age = 0;
                end
            end else begin
                age++;
                if (rv) begin
                    open = 0; age = 0;
                    if (own_if) begin
                        exp_ifv = 1; exp_ifd = rd[31:0];
                    end else begin
                        exp_dmv = 1; exp_dmd = own_store ? 64'h0 : rd;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
